// File: rtl/uart_frame_pkg.sv
// Shared framing constants for MNIST result UART senders.
// Contents: header bytes, frame geometry, FSM state encoding, result snapshot type.
package uart_frame_pkg;

  localparam logic [7:0]  FRAME_HDR0  = 8'hAA;
  localparam logic [7:0]  FRAME_HDR1  = 8'h55;
  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned SCORE_W     = 16;
  // header0, header1, class, two bytes per score, checksum
  localparam int unsigned FRAME_LEN   = 3 + 2 * NUM_CLASSES + 1;
  localparam int unsigned IDX_W       = $clog2(FRAME_LEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef logic [IDX_W-1:0] byte_idx_t;

  // Classifier result captured at accept time.
  typedef struct packed {
    logic [3:0]                       cls;
    logic [NUM_CLASSES*SCORE_W-1:0]   scores;
  } result_t;

  // True for the bytes covered by the checksum (class byte and all score bytes).
  function automatic logic in_chk_span(input byte_idx_t idx);
    return (idx >= IDX_W'(2)) && (idx <= IDX_W'(FRAME_LEN - 2));
  endfunction

endpackage

// File: rtl/uart_byte_pacer.sv
// Fixed-budget byte pacer for UART transmitters without a busy output.
// Ports: sys_clk, sys_rst_n (async active-low), start (1-cycle pulse),
//        done_c (combinational 1-cycle pulse, BYTE_CYCLES-1 cycles after start).
module uart_byte_pacer #(
  parameter int unsigned BYTE_CYCLES = 4774
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic start,
  output logic done_c
);

  localparam int unsigned    CNT_W = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTE_CYCLES - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;

  // cnt sits at 0 during the start cycle, so done lands BYTE_CYCLES-1 cycles later.
  assign done_c = active && (cnt == LAST);

  // Gap counter; cleared when the budget expires so it reads 0 at the next start.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CNT_W'(1);
    end else if (done_c) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_result_sender.sv
// Frames one MNIST result (class + 10 scores) into a 24-byte UART packet
// and hands it to uart_tx one byte per BYTE_CYCLES.
// Ports: sys_clk, sys_rst_n (async active-low); res_valid/res_ready handshake with
//        res_class and flattened res_scores; po_data/po_flag to uart_tx; busy.
module uart_result_sender
  import uart_frame_pkg::*;
#(
  parameter int unsigned UART_BPS    = 115200,
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BYTE_CYCLES = (CLK_FREQ / UART_BPS) * 11
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           res_valid,
  output logic                           res_ready,
  input  logic [3:0]                     res_class,
  input  logic [NUM_CLASSES*SCORE_W-1:0] res_scores,
  output logic [7:0]                     po_data,
  output logic                           po_flag,
  output logic                           busy
);

  localparam byte_idx_t LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [1:0]          state, state_nxt;
  byte_idx_t           idx, idx_nxt, off;
  result_t             snap;
  logic [7:0]          chk, byte_c;
  logic [SCORE_W-1:0]  score_c;
  logic                accept_c, load_c, pace_start_c, pace_done_c;

  assign accept_c     = res_valid & res_ready;
  assign pace_start_c = (state == ST_LOAD);

  uart_byte_pacer #(.BYTE_CYCLES(BYTE_CYCLES)) u_pacer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (pace_start_c),
    .done_c    (pace_done_c)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next state and byte index; load_c marks the edge that enters LOAD.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: if (accept_c) begin
        state_nxt = ST_LOAD;
        idx_nxt   = '0;
      end
      ST_LOAD: state_nxt = ST_GAP;
      ST_GAP: if (pace_done_c) begin
        if (idx == LAST_IDX) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_LOAD;
          idx_nxt   = idx + IDX_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    load_c = (state_nxt == ST_LOAD);
  end

  // Byte mux for the index about to be loaded. Header bytes need no snapshot,
  // so selecting on the accept edge is safe.
  always_comb begin
    off     = idx_nxt - IDX_W'(3);
    score_c = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (off[IDX_W-1:1] == (IDX_W-1)'(k)) score_c = snap.scores[k*SCORE_W +: SCORE_W];
    end
    if (idx_nxt == IDX_W'(0))      byte_c = FRAME_HDR0;
    else if (idx_nxt == IDX_W'(1)) byte_c = FRAME_HDR1;
    else if (idx_nxt == IDX_W'(2)) byte_c = {4'h0, snap.cls};
    else if (idx_nxt == LAST_IDX)  byte_c = chk;
    else if (off[0])               byte_c = score_c[7:0];
    else                           byte_c = score_c[SCORE_W-1 -: 8];
  end

  // Registered outputs, snapshot and running checksum.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx       <= '0;
      snap      <= '0;
      chk       <= 8'h00;
      po_data   <= 8'h00;
      po_flag   <= 1'b0;
      busy      <= 1'b0;
      res_ready <= 1'b1;
    end else begin
      idx       <= idx_nxt;
      po_flag   <= load_c;
      busy      <= (state_nxt != ST_IDLE);
      res_ready <= (state_nxt == ST_IDLE);
      if (accept_c) begin
        snap.cls    <= res_class;
        snap.scores <= res_scores;
        chk         <= 8'h00;
      end
      if (load_c) begin
        po_data <= byte_c;
        if (in_chk_span(idx_nxt)) chk <= chk + byte_c;
      end
    end
  end

endmodule
